// File: rtl/constants_pkg.sv
// Shared constants and types for the instruction-fetch path.
// ICLLEN sets the cache line width; ICACHE_OFF_W is the byte-offset width of one line.
package constants_pkg;

   localparam int ICLLEN       = 128;
   localparam int ICACHE_OFF_W = $clog2(ICLLEN / 8);

   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache_fetch_if.sv
// instruction_bus: line-load channel between the instruction cache (consumer)
// and main memory (producer). ldData is valid only while ldr is high.
interface instruction_bus
   import constants_pkg::*;
#(
   parameter int ADDR_W = 32
) ();

   logic              ldp;
   logic [ADDR_W-1:0] ldAddr;
   logic              ldr;
   logic [ICLLEN-1:0] ldData;

   modport consumer (
      output ldp,
      output ldAddr,
      input  ldr,
      input  ldData
   );

   modport producer (
      input  ldp,
      input  ldAddr,
      output ldr,
      output ldData
   );

endinterface

// File: rtl/icache_tag_array.sv
// Tag and valid storage for a direct-mapped instruction cache.
// Combinational lookup, one write port, and a flush that clears every valid bit.
module icache_tag_array #(
   parameter int NUM_LINES = 4,
   parameter int TAG_W     = 26
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(NUM_LINES)-1:0] lookup_idx,
   input  logic [TAG_W-1:0]             lookup_tag,
   output logic                         lookup_hit,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_LINES)-1:0] wr_idx,
   input  logic [TAG_W-1:0]             wr_tag,
   input  logic                         wr_valid,
   input  logic                         flush
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q [NUM_LINES];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         if (wr_en) valid_q[wr_idx] <= wr_valid;
         // Flush is applied last so it overrides a fill landing on the same edge.
         if (flush) valid_q <= '0;
      end
   end

   // NOTE: tag storage has no reset; the valid bits alone make stale tags harmless,
   // and leaving memories unreset lets them map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) tag_q[wr_idx] <= wr_tag;
   end

   assign lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache: same-cycle hits, single-line refill over instruction_bus.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_fetch
   import constants_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_pc,
   input  logic              f_flush,
   output logic              f_valid,
   output logic [31:0]       f_instr,
   output logic              f_stall,
`ifdef ICACHE_STATS_EN
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
`endif
   instruction_bus.consumer  bus
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - ICACHE_OFF_W - IDX_W;
   localparam int SEL_W = ICACHE_OFF_W - 2;

   icache_state_t     state_q, state_d;
   logic              ldp_q, ldp_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              discard_q, discard_d;
   logic              fill_en;
   logic              tag_hit;
   logic              hit;

   logic [IDX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic [SEL_W-1:0]  pc_sel;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;

   logic [ICLLEN-1:0] data_q [NUM_LINES];
   logic [ICLLEN-1:0] line_rd;

   assign pc_idx   = f_pc[ICACHE_OFF_W +: IDX_W];
   assign pc_tag   = f_pc[ADDR_W-1 -: TAG_W];
   assign pc_sel   = f_pc[ICACHE_OFF_W-1:2];
   // The fill target comes from the latched line address, since f_pc may move if f_req drops.
   assign fill_idx = addr_q[ICACHE_OFF_W +: IDX_W];
   assign fill_tag = addr_q[ADDR_W-1 -: TAG_W];

   icache_tag_array #(
      .NUM_LINES (NUM_LINES),
      .TAG_W     (TAG_W)
   ) u_tags (
      .clk        (clk),
      .rst        (rst),
      .lookup_idx (pc_idx),
      .lookup_tag (pc_tag),
      .lookup_hit (tag_hit),
      .wr_en      (fill_en),
      .wr_idx     (fill_idx),
      .wr_tag     (fill_tag),
      .wr_valid   (~discard_q),
      .flush      (f_flush)
   );

   always_ff @(posedge clk) begin
      if (fill_en) data_q[fill_idx] <= bus.ldData;
   end

   assign hit     = f_req && (state_q == IDLE) && tag_hit;
   assign line_rd = data_q[pc_idx];
   assign f_valid = hit;
   assign f_instr = hit ? line_rd[32*pc_sel +: 32] : 32'd0;
   assign f_stall = f_req && !hit;

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ldp_d     = ldp_q;
      addr_d    = addr_q;
      discard_d = discard_q;
      fill_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (f_req && !tag_hit) begin
               state_d = REFILL;
               ldp_d   = 1'b1;
               addr_d  = {f_pc[ADDR_W-1:ICACHE_OFF_W], {ICACHE_OFF_W{1'b0}}};
            end
         end
         REFILL: begin
            if (bus.ldr) begin
               fill_en   = 1'b1;
               ldp_d     = 1'b0;
               discard_d = 1'b0;
               state_d   = IDLE;
            end else if (f_flush) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ldp_q     <= 1'b0;
         addr_q    <= '0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ldp_q     <= ldp_d;
         addr_q    <= addr_d;
         discard_q <= discard_d;
      end
   end

   assign bus.ldp    = ldp_q;
   assign bus.ldAddr = addr_q;

`ifdef ICACHE_STATS_EN
   logic miss_start;
   assign miss_start = (state_q == IDLE) && (state_d == REFILL);

   // Saturating counters; flush does not touch them.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (f_valid && (hit_count != 32'hFFFF_FFFF))     hit_count  <= hit_count + 32'd1;
         if (miss_start && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios followed by randomized
// fetch/flush traffic checked against a line-address level cache model.
`timescale 1ns/1ps
module tb_icache_fetch;
   import constants_pkg::*;

   localparam int NUM_LINES = 4;
   localparam int ADDR_W    = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              f_req;
   logic [ADDR_W-1:0] f_pc;
   logic              f_flush;
   logic              f_valid;
   logic [31:0]       f_instr;
   logic              f_stall;
`ifdef ICACHE_STATS_EN
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;
`endif

   instruction_bus #(.ADDR_W(ADDR_W)) bus ();

   icache_fetch #(.NUM_LINES(NUM_LINES), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .f_req      (f_req),
      .f_pc       (f_pc),
      .f_flush    (f_flush),
      .f_valid    (f_valid),
      .f_instr    (f_instr),
      .f_stall    (f_stall),
`ifdef ICACHE_STATS_EN
      .hit_count  (hit_count),
      .miss_count (miss_count),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Memory image: a fixed function of the line address; line 0 holds the known program words.
   function automatic logic [127:0] mem_line(input logic [31:0] a);
      return {32'hfe1088e3 ^ (a * 32'd3), 32'h0040a103 ^ (a << 3),
              32'h0010a223 ^ {a[15:0], a[31:16]}, 32'h40010093 ^ (a * 32'd7)};
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      logic [127:0] l;
      l = mem_line({pc[31:4], 4'b0});
      return l[32*pc[3:2] +: 32];
   endfunction

   // Memory responder: answers each ldp with a single ldr pulse resp_lat cycles later.
   int resp_lat  = 1;
   int resp_cnt  = 0;
   bit resp_busy = 1'b0;

   always begin
      @(posedge clk);
      #1;
      bus.ldr    = 1'b0;
      bus.ldData = {$urandom, $urandom, $urandom, $urandom};
      if (resp_busy) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            bus.ldr    = 1'b1;
            bus.ldData = mem_line(bus.ldAddr);
            resp_busy  = 1'b0;
         end
      end else if (bus.ldp) begin
         resp_busy = 1'b1;
         resp_cnt  = resp_lat;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!f_valid && n < budget) begin
         tick();
         settle();
         n++;
      end
      check({tag, " valid"}, 128'(f_valid), 128'(1'b1));
   endtask

   // Reference model state for the randomized phase.
   bit          m_valid [NUM_LINES];
   logic [31:0] m_line  [NUM_LINES];
   bit          m_out;
   bit          m_disc;
   logic [31:0] m_pend;
   int unsigned m_hits;
   int unsigned m_miss;

   logic [31:0] pool [8] = '{32'h0000_0000, 32'h0000_0040, 32'h0000_0080, 32'h0000_00C0,
                             32'h0000_0010, 32'h0000_0050, 32'h0000_0020, 32'h0000_1230};

   initial begin
      logic [31:0] line;
      logic [1:0]  w;
      logic [1:0]  b;
      int          idx;
      int          pidx;
      bit          exp_hit;
      bit          stalled_prev;

      rst     = 1'b1;
      f_req   = 1'b0;
      f_pc    = '0;
      f_flush = 1'b0;
      bus.ldr = 1'b0;
      bus.ldData = '0;

      // Reset state
      tick(); tick(); settle();
      check("reset ldp",     128'(bus.ldp),    128'(1'b0));
      check("reset ldAddr",  128'(bus.ldAddr), 128'(32'd0));
      check("reset f_valid", 128'(f_valid),    128'(1'b0));
      check("reset f_stall", 128'(f_stall),    128'(1'b0));
      check("reset f_instr", 128'(f_instr),    128'(32'd0));

      // Cold miss at cycle t
      tick(); rst = 1'b0; f_req = 1'b1; f_pc = 32'h0; settle();
      check("cold t f_valid", 128'(f_valid), 128'(1'b0));
      check("cold t f_stall", 128'(f_stall), 128'(1'b1));
      check("cold t ldp",     128'(bus.ldp), 128'(1'b0));
      tick(); settle();
      check("cold t+1 ldp",    128'(bus.ldp),    128'(1'b1));
      check("cold t+1 ldAddr", 128'(bus.ldAddr), 128'(32'h0));
      tick(); settle();
      check("cold t+2 ldp held", 128'(bus.ldp), 128'(1'b1));
      tick(); settle();
      check("cold t+3 ldp",     128'(bus.ldp),  128'(1'b0));
      check("cold t+3 f_valid", 128'(f_valid),  128'(1'b1));
      check("cold t+3 f_instr", 128'(f_instr),  128'(32'h40010093));

      // Hits on the remaining words
      tick(); f_pc = 32'h4; settle();
      check("hit 0x4 instr", 128'(f_instr), 128'(32'h0010a223));
      check("hit 0x4 stall", 128'(f_stall), 128'(1'b0));
      tick(); f_pc = 32'h8; settle();
      check("hit 0x8 instr", 128'(f_instr), 128'(32'h0040a103));
      check("hit 0x8 ldp",   128'(bus.ldp), 128'(1'b0));
      tick(); f_pc = 32'hC; settle();
      check("hit 0xC instr", 128'(f_instr), 128'(32'hfe1088e3));
      check("hit 0xC stall", 128'(f_stall), 128'(1'b0));
      tick(); f_req = 1'b0; settle();
      check("idle f_valid", 128'(f_valid), 128'(1'b0));
      check("idle f_instr", 128'(f_instr), 128'(32'd0));
      check("idle ldp",     128'(bus.ldp), 128'(1'b0));
`ifdef ICACHE_STATS_EN
      check("stats miss_count", 128'(miss_count), 128'(32'd1));
      check("stats hit_count",  128'(hit_count),  128'(32'd4));
`endif

      // Conflict miss: 0x40 evicts 0x0 from index 0
      tick(); f_req = 1'b1; f_pc = 32'h40; settle();
      check("conflict 0x40 miss", 128'(f_valid), 128'(1'b0));
      tick(); settle();
      check("conflict ldAddr 0x40", 128'(bus.ldAddr), 128'(32'h40));
      wait_valid("conflict 0x40", 10);
      check("conflict 0x40 instr", 128'(f_instr), 128'(mem_word(32'h40)));
      tick(); f_pc = 32'h0; settle();
      check("refetch 0x0 miss", 128'(f_valid), 128'(1'b0));
      tick(); settle();
      check("refetch ldAddr 0x0", 128'(bus.ldAddr), 128'(32'h0));
      wait_valid("refetch 0x0", 10);
      check("refetch 0x0 instr", 128'(f_instr), 128'(32'h40010093));

      // Flush one cycle after ldp rises
      resp_lat = 2;
      tick(); f_pc = 32'h80; settle();
      check("flush miss", 128'(f_valid), 128'(1'b0));
      tick(); settle();
      check("flush ldp rise", 128'(bus.ldp), 128'(1'b1));
      tick(); f_flush = 1'b1; settle();
      tick(); f_flush = 1'b0; settle();
      check("flush ldp at ldr", 128'(bus.ldp), 128'(1'b1));
      tick(); settle();
      check("flush discarded valid", 128'(f_valid), 128'(1'b0));
      check("flush ldp low",         128'(bus.ldp), 128'(1'b0));
      tick(); settle();
      check("flush re-miss ldp",    128'(bus.ldp),    128'(1'b1));
      check("flush re-miss ldAddr", 128'(bus.ldAddr), 128'(32'h80));
      wait_valid("flush refill", 10);
      check("flush refill instr", 128'(f_instr), 128'(mem_word(32'h80)));

      // Reset in the middle of a refill, then a stray ldr
      resp_lat = 3;
      tick(); f_pc = 32'hC4; settle();
      tick(); settle();
      check("rst-mid ldp rise", 128'(bus.ldp), 128'(1'b1));
      tick(); rst = 1'b1; f_req = 1'b0; settle();
      tick(); rst = 1'b0; settle();
      check("rst-mid ldp",    128'(bus.ldp),    128'(1'b0));
      check("rst-mid ldAddr", 128'(bus.ldAddr), 128'(32'h0));
      tick(); settle();
      check("stray ldr ldp", 128'(bus.ldp), 128'(1'b0));
      tick(); f_req = 1'b1; f_pc = 32'hC4; settle();
      check("post-rst 0xC4 miss", 128'(f_valid), 128'(1'b0));
      tick(); settle();
      check("post-rst ldp",    128'(bus.ldp),    128'(1'b1));
      check("post-rst ldAddr", 128'(bus.ldAddr), 128'(32'hC0));
`ifdef ICACHE_STATS_EN
      check("post-rst miss_count", 128'(miss_count), 128'(32'd1));
`endif
      wait_valid("post-rst refill", 10);
      check("post-rst instr", 128'(f_instr), 128'(mem_word(32'hC4)));

      // Randomized traffic against the model, from a clean reset
      tick(); rst = 1'b1; f_req = 1'b0; f_flush = 1'b0;
      tick(); rst = 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
         m_valid[i] = 1'b0;
         m_line[i]  = '0;
      end
      m_out = 1'b0; m_disc = 1'b0; m_pend = '0; m_hits = 0; m_miss = 0;
      stalled_prev = 1'b0;

      for (int n = 0; n < 1500; n++) begin
         tick();
         if (stalled_prev) begin
            if (m_out && $urandom_range(0, 9) == 0) f_req = 1'b0;
         end else begin
            w     = 2'($urandom_range(0, 3));
            b     = 2'($urandom_range(0, 3));
            f_req = ($urandom_range(0, 4) != 0);
            f_pc  = pool[$urandom_range(0, 7)] | {28'd0, w, b};
         end
         f_flush  = ($urandom_range(0, 24) == 0);
         resp_lat = int'($urandom_range(1, 3));
         settle();

         line    = {f_pc[31:4], 4'b0};
         idx     = int'(line[31:4]) % NUM_LINES;
         exp_hit = f_req && !m_out && m_valid[idx] && (m_line[idx] == line);
         check("rand f_valid", 128'(f_valid), 128'(exp_hit));
         check("rand f_instr", 128'(f_instr), 128'(exp_hit ? mem_word(f_pc) : 32'd0));
         check("rand f_stall", 128'(f_stall), 128'(f_req && !exp_hit));
         check("rand ldp",     128'(bus.ldp), 128'(m_out));
         if (m_out) check("rand ldAddr", 128'(bus.ldAddr), 128'(m_pend));
`ifdef ICACHE_STATS_EN
         check("rand hit_count",  128'(hit_count),  128'(m_hits));
         check("rand miss_count", 128'(miss_count), 128'(m_miss));
`endif
         stalled_prev = f_req && !exp_hit;

         if (m_out) begin
            if (bus.ldr) begin
               pidx = int'(m_pend[31:4]) % NUM_LINES;
               if (!m_disc && !f_flush) begin
                  m_valid[pidx] = 1'b1;
                  m_line[pidx]  = m_pend;
               end
               m_out  = 1'b0;
               m_disc = 1'b0;
            end else if (f_flush) begin
               m_disc = 1'b1;
            end
         end else if (f_req && !exp_hit) begin
            m_out  = 1'b1;
            m_pend = line;
            m_miss++;
         end
         if (f_flush)
            for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
         if (exp_hit) m_hits++;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache controller between the core's fetch stage and main memory.
- Acts as the consumer (requesting) end of the instruction_bus.
- Serves 32-bit instruction fetches from ICLLEN-bit lines in the same cycle on a hit.
- On a miss, issues a line load over instruction_bus, fills the line, then serves the fetch.

Parameters:
- NUM_LINES, 4: number of cache lines. Power of two, ≥2.
- ADDR_W, 32: fetch address width.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- f_req  input  1  core fetch request. Held with f_pc stable while f_stall=1.
- f_pc  input  ADDR_W  fetch byte address; bits [1:0] ignored.
- f_flush  input  1  one-cycle pulse; invalidates all lines (fence.i).
- f_valid  output  1  f_instr valid this cycle.
- f_instr  output  32  fetched instruction.
- f_stall  output  1  f_req & ~f_valid.
- bus  modport  instruction_bus.consumer  uses the following members:
  - bus.ldp out 1: load request.
  - bus.ldAddr out ADDR_W: line-aligned address.
  - bus.ldr in 1: one-cycle ready pulse.
  - bus.ldData in ICLLEN: line data, valid while ldr=1.

Behaviour:
- Address split:
  - OFF = log2(ICLLEN/8) bits (4 for 128).
  - Word select = f_pc[OFF-1:2]; word k = line[32k+31:32k].
  - Index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Storage per line: data (ICLLEN), tag, and a valid bit. Valid bits are registers; data/tag need no reset.
- Hit (combinational): f_req & valid[idx] & tag match & state==IDLE.
  - f_valid=1, f_instr = selected word, same cycle.
  - When f_valid=0, f_instr=0.
- State machine, two states:
  - IDLE:
    - On f_req with a miss: latch line address {f_pc[ADDR_W-1:OFF], OFF'b0} into bus.ldAddr.
    - Set bus.ldp←1 and go to REFILL.
  - REFILL:
    - bus.ldp is held 1 until bus.ldr is sampled high.
    - On that edge: write data = bus.ldData, set tag and valid[idx] (unless discard is set).
    - Also on that edge: bus.ldp←0, state←IDLE.
    - ldp must be low the cycle after ldr so the responder does not re-serve.
- Latency with the standard responder (ldr two cycles after ldp rises): miss at cycle t gives the hit at t+3.
- bus.ldr seen while in IDLE is ignored; no state or storage change.
- f_flush:
  - In IDLE: all valid bits ←0 at the edge. A same-cycle hit is still delivered.
  - In REFILL: all valid bits ←0 and a discard flag is set.
  - With discard set, the returning line is written but not marked valid; discard clears on ldr.
  - The core then re-misses.
- Reset values:
  - state=IDLE, bus.ldp=0, bus.ldAddr=0, all valid=0, discard=0.
  - f_valid=0, f_stall=0, f_instr=0.
- Reset mid-REFILL: the same reset values apply. Any ldr pulse arriving afterwards is ignored.
- f_req dropped during REFILL: the refill still completes and fills the line. No f_valid is produced.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined, adds two ports:
  - hit_count output 32: increments on each cycle with f_valid=1.
  - miss_count output 32: increments on each IDLE→REFILL transition.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are unaffected by f_flush.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- ICLLEN comes from constants_pkg.
- Add to constants_pkg:
  - icache_state_t enum (IDLE, REFILL).
  - ICACHE_OFF_W derived from ICLLEN.
- One sub-module: icache_tag_array.
  - Holds tag and valid storage for NUM_LINES.
  - Provides combinational lookup, a write port, and a flush-all input.
- The data array and FSM stay in icache_fetch.

Test Plan:
- Cold miss: after reset, f_req=1 with f_pc=0x0000_0000, and memory returns ldData=128'hfe1088e3_0040a103_0010a223_40010093.
  - ldp rises at t+1 with ldAddr=0.
  - ldp falls after the ldr edge.
  - f_valid=1 with f_instr=0x40010093 at t+3.
- Hit all words: f_pc=0x4, 0x8, 0xC on consecutive cycles.
  - f_instr=0x0010a223, 0x0040a103, 0xfe1088e3, each same cycle.
  - f_stall=0 and ldp stays 0.
- Conflict miss: with NUM_LINES=4, fetch 0x0 then 0x40 (same index, different tag).
  - Second fetch issues ldAddr=0x40 and refills.
  - Re-fetching 0x0 misses again.
- Flush during REFILL: pulse f_flush one cycle after ldp rises.
  - The line is filled but valid stays 0.
  - The held f_req re-misses, producing a second ldp with the same ldAddr.
- Reset mid-REFILL: assert rst while ldp=1, release it, and let a stray ldr arrive.
  - ldp=0, no valid bit is set, and the next fetch misses.
- ICACHE_STATS_EN: cold miss then 3 hits → miss_count=1, hit_count=4.
